// File: rtl/display_pkg.sv
// display_pkg: segment patterns and scan enums shared by the display controller
package display_pkg;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  typedef enum logic [1:0] {DIG_L1, DIG_L2, DIG_L3, DIG_L4} digit_e;
  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;
  typedef struct packed {
    logic        sw;
    logic [15:0] digits;
    logic        pm;
    logic        mil;
    logic        set_hour;
    logic        set_minute;
  } frame_t;
endpackage

// File: rtl/display_scan_controller_seg7_decode.sv
// seg7_decode: BCD to {a..g} segments, dash for codes 10-15
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: 4-digit multiplexed 7-segment scan with per-frame
// source latch, anti-ghost blanking, leading-zero suppression, PM/colon dp and set-mode blink
module display_scan_controller
  import display_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_HZ     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] clk_digits,
  input  logic        clk_pm,
  input  logic        military,
  input  logic [15:0] sw_digits,
  input  logic        sw_enable,
  input  logic        set_hour,
  input  logic        set_minute,
  input  logic        sec_pulse,
  output logic [3:0]  digit_en,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_done
);
  localparam int TICKS = CLK_HZ / SCAN_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW = $clog2(TICKS + 1);
  localparam int BW = $clog2(HALF + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  digit_e        dig_q, dig_d;
  scan_state_e   state_q, state_d;
  frame_t        frame_q, frame_d;
  logic          phase_q, phase_d, colon_q, colon_d;
  logic          wrap, frame_end, blink_wrap, hide, dp_d;
  logic [3:0]    bcd;
  logic [6:0]    seg;
  seg7_decode u_dec (.bcd_i(bcd), .seg_o(seg));
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt_q <= '0;
      blink_cnt_q <= '0;
      dig_q <= DIG_L1;
      state_q <= ST_BLANK;
      frame_q <= '0;
      phase_q <= 1'b1;
      colon_q <= 1'b1;
      digit_en <= '0;
      segments <= SEG_OFF;
      dp <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      dig_q <= dig_d;
      state_q <= state_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      colon_q <= colon_d;
      digit_en <= state_q == ST_DRIVE ? 4'b1000 >> dig_q : 4'b0000;
      segments <= state_q == ST_DRIVE && !hide ? seg : SEG_OFF;
      dp <= state_q == ST_DRIVE && dp_d;
      frame_done <= frame_end;
    end
  always_comb begin
    wrap = cnt_q == CW'(TICKS - 1);
    frame_end = wrap && dig_q == DIG_L4;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    dig_d = wrap ? digit_e'(dig_q + 2'd1) : dig_q;
    state_d = cnt_d < CW'(BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
    blink_wrap = blink_cnt_q == BW'(HALF - 1);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d = phase_q ^ blink_wrap;
    colon_d = colon_q ^ sec_pulse;
    // Everything the display policy depends on is frozen here for a whole frame
    frame_d = frame_end ? frame_t'{sw: sw_enable, digits: sw_enable ? sw_digits : clk_digits,
                                   pm: clk_pm, mil: military, set_hour: set_hour,
                                   set_minute: set_minute} : frame_q;
    bcd = frame_q.digits[{~dig_q, 2'b00} +: 4];
    // dig_q[1] splits the hour pair (L1/L2) from the minute pair (L3/L4)
    hide = !frame_q.sw && ((!frame_q.mil && dig_q == DIG_L1 && bcd == 4'd0) ||
           (!phase_q && (frame_q.set_hour ? !dig_q[1] : frame_q.set_minute && dig_q[1])));
    dp_d = dig_q == DIG_L2 ? frame_q.sw || colon_q
         : dig_q == DIG_L4 && !frame_q.sw && frame_q.pm && !frame_q.mil;
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: table vectors, corner sequences and random stimulus against a cycle-index model
module tb_display_scan_controller;
  localparam int T = 10, BL = 2, HALF = 20;
  localparam logic [6:0] SEGTAB [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
  logic clk = 0, reset_n = 0;
  logic [15:0] clk_digits = 0, sw_digits = 0;
  logic clk_pm = 0, military = 0, sw_enable = 0, set_hour = 0, set_minute = 0, sec_pulse = 0;
  logic [3:0] digit_en;
  logic [6:0] segments;
  logic dp, frame_done;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  display_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .BLINK_HZ(25)) dut (
    .clk(clk), .reset_n(reset_n), .clk_digits(clk_digits), .clk_pm(clk_pm), .military(military),
    .sw_digits(sw_digits), .sw_enable(sw_enable), .set_hour(set_hour), .set_minute(set_minute),
    .sec_pulse(sec_pulse), .digit_en(digit_en), .segments(segments), .dp(dp), .frame_done(frame_done));
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
  endtask
  // Model: n counts cycles since reset; slot, digit and blink phase follow from n by division
  typedef struct {logic sw; logic [15:0] d; logic pm, mil, sh, sm;} lat_t;
  lat_t lat;
  int n;
  logic colon, e_dp, e_fd;
  logic [3:0] e_en;
  logic [6:0] e_seg;
  bit model_on = 0;
  always @(posedge clk)
    if (!reset_n) begin
      n = 0; colon = 1; lat = '{default: 0};
      e_en = 0; e_seg = 0; e_dp = 0; e_fd = 0;
    end else begin
      int dig, pos;
      logic [3:0] b;
      logic hide, on;
      pos = n % T;
      dig = (n / T) % 4;
      on = ((n / HALF) % 2) == 0;
      b = lat.d[4*(3-dig) +: 4];
      hide = !lat.sw && ((!lat.mil && dig == 0 && b == 0) ||
             (!on && (lat.sh ? dig < 2 : lat.sm && dig >= 2)));
      e_en = pos >= BL ? 4'b1000 >> dig : 4'b0000;
      e_seg = (pos >= BL && !hide) ? SEGTAB[b] : 7'b0;
      e_dp = pos >= BL && (dig == 1 ? (lat.sw || colon) : (dig == 3 && !lat.sw && lat.pm && !lat.mil));
      e_fd = (n % (4*T)) == 4*T - 1;
      if (sec_pulse) colon = !colon;
      if (e_fd) lat = '{sw_enable, sw_enable ? sw_digits : clk_digits, clk_pm, military, set_hour, set_minute};
      n++;
    end
  always @(negedge clk)
    if (model_on) begin
      chk("model_digit_en", digit_en, e_en);
      chk("model_segments", segments, e_seg);
      chk("model_dp", dp, e_dp);
      chk("model_frame_done", frame_done, e_fd);
    end
  typedef struct {logic sw; logic [15:0] swd, cd; logic pm, mil, sh, sm; logic [6:0] s1, s2, s3, s4; logic dp2, dp4;} vec_t;
  vec_t tbl[8];
  task automatic wait_fd(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!frame_done && k < 100);
    chk("frame_done_timeout", k < 100, 1);
  endtask
  task automatic apply(input vec_t v);
    sw_enable = v.sw; sw_digits = v.swd; clk_digits = v.cd;
    clk_pm = v.pm; military = v.mil; set_hour = v.sh; set_minute = v.sm;
  endtask
  task automatic check_frame(input string nm, input vec_t v);
    logic [6:0] s [4];
    s = '{v.s1, v.s2, v.s3, v.s4};
    repeat (6) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk({nm, "_en"}, digit_en, 4'b1000 >> d);
      chk({nm, "_seg"}, segments, s[d]);
      if (d == 3) chk({nm, "_dp_l4"}, dp, v.dp4);
      if (d == 1 && v.sw) chk({nm, "_dp_l2"}, dp, v.dp2);
      if (d < 3) repeat (10) @(negedge clk);
    end
  endtask
  task automatic first_enable(input string nm);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (digit_en != 4'b1000 && k < 10);
    chk(nm, k, 3);
  endtask
  initial begin
    int k;
    tbl[0] = '{1'b0, 16'h0000, 16'h0945, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 7'b1111011, 7'b0110011, 7'b1011011, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 16'h0000, 16'h0945, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111110, 7'b1111011, 7'b0110011, 7'b1011011, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0110000, 7'b1101101, 7'b1111001, 7'b1111110, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 16'h0A5F, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 7'b0000001, 7'b1011011, 7'b0000001, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 16'h1859, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0110000, 7'b1111111, 7'b0000000, 7'b0000000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 16'h1859, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0110000, 7'b1111111, 7'b1011011, 7'b1111011, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'h5A07, 16'h0945, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1011011, 7'b0000001, 7'b1111110, 7'b1110000, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 16'h0062, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1111110, 7'b1111110, 7'b1011111, 7'b1101101, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    model_on = 1;
    chk("reset_digit_en", digit_en, 0);
    chk("reset_segments", segments, 0);
    chk("reset_dp", dp, 0);
    chk("reset_frame_done", frame_done, 0);
    reset_n = 1;
    first_enable("first_enable_latency");
    wait_fd(k);
    wait_fd(k);
    chk("frame_period", k, 40);
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i]);
      wait_fd(k);
      check_frame($sformatf("vec%0d", i), tbl[i]);
    end
    // Colon: L2 dp toggles one output cycle after the edge that sees sec_pulse
    apply(tbl[0]);
    wait_fd(k);
    wait_fd(k);
    repeat (16) @(negedge clk);
    chk("colon_on", dp, 1);
    sec_pulse = 1;
    @(negedge clk);
    sec_pulse = 0;
    @(negedge clk);
    chk("colon_toggled", dp, 0);
    // Mid-frame input change is held off until the next frame
    wait_fd(k);
    repeat (16) @(negedge clk);
    chk("midframe_l2", segments, 7'b1111011);
    clk_digits = 16'h1230;
    clk_pm = 0;
    repeat (10) @(negedge clk);
    chk("midframe_l3_old", segments, 7'b0110011);
    repeat (10) @(negedge clk);
    chk("midframe_l4_old", segments, 7'b1011011);
    chk("midframe_l4_dp_old", dp, 1);
    wait_fd(k);
    check_frame("midframe_new", tbl[2]);
    // Source switch mid-frame
    wait_fd(k);
    repeat (16) @(negedge clk);
    sw_enable = 1;
    sw_digits = 16'h5A07;
    repeat (10) @(negedge clk);
    chk("sw_switch_l3_old", segments, 7'b1111001);
    wait_fd(k);
    check_frame("sw_switch_new", tbl[6]);
    // Reset mid-frame
    repeat (13) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("midreset_digit_en", digit_en, 0);
    chk("midreset_segments", segments, 0);
    chk("midreset_dp", dp, 0);
    reset_n = 1;
    first_enable("midreset_enable_latency");
    // Random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset_n = $urandom_range(0, 499) != 0;
      clk_digits = 16'($urandom);
      sw_digits = 16'($urandom);
      clk_pm = 1'($urandom);
      military = 1'($urandom);
      set_hour = $urandom_range(0, 3) == 0;
      set_minute = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 29) == 0) sw_enable = !sw_enable;
      sec_pulse = $urandom_range(0, 7) == 0;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
